alu_mul_seq: RTL and testbench

Sequential shift-add multiplier controller that drives an external `aluN` instance, one add step per clock. It multiplies two unsigned N-bit operands into a 2N-bit product in N cycles. The ALU is shared only through this block's `alu_*` ports, and the ALU is purely combinational. The block sits between the ALU datapath and whatever issues multiply requests, such as a decoder or a test FSM.

---
 rtl/alu_mul_seq.sv | 77 +++++++
 tb/tb_alu_mul_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier controller that drives an external combinational ALU.
// One add-and-shift step per clock, so an N x N multiply takes N steps.
module alu_mul_seq #(
    parameter int         N       = 4,
    parameter logic [3:0] OPE_ADD = 4'b0010
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic           alu_c_o,
    output logic [3:0]     alu_ope_o,
    input  logic [N-1:0]   alu_sal_i,
    input  logic           alu_c_i
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  m;
    logic [N-1:0]  p_hi;
    logic [N-1:0]  p_lo;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        m     <= mcand_i;
                        p_hi  <= '0;
                        p_lo  <= mplier_i;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Right shift of {carry, sum, P_lo}; the consumed multiplier bit falls out.
                    {p_hi, p_lo} <= {alu_c_i, alu_sal_i, p_lo[N-1:1]};
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign product_o = {p_hi, p_lo};

    // ALU is fed in every state; its result is only consumed during RUN.
    assign alu_a_o   = p_hi;
    assign alu_b_o   = p_lo[0] ? m : '0;
    assign alu_c_o   = 1'b0;
    assign alu_ope_o = OPE_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: N=4 directed/exhaustive and N=8 random, each against a*b
// with a behavioural ALU attached.
module tb_alu_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int tests = 0;
    int fails = 0;

    // N=4 instance
    logic       s4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [7:0] prod4;
    logic [3:0] aa4, ab4, sal4, ope4;
    logic       ac4, c4;

    // N=8 instance
    logic        s8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic [7:0]  aa8, ab8, sal8;
    logic [3:0]  ope8;
    logic        ac8, c8;

    alu_mul_seq #(.N(4), .OPE_ADD(4'b0010)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(s4), .mcand_i(a4), .mplier_i(b4),
        .busy_o(busy4), .done_o(done4), .product_o(prod4),
        .alu_a_o(aa4), .alu_b_o(ab4), .alu_c_o(ac4), .alu_ope_o(ope4),
        .alu_sal_i(sal4), .alu_c_i(c4)
    );

    alu_mul_seq #(.N(8), .OPE_ADD(4'b0010)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8), .mcand_i(a8), .mplier_i(b8),
        .busy_o(busy8), .done_o(done8), .product_o(prod8),
        .alu_a_o(aa8), .alu_b_o(ab8), .alu_c_o(ac8), .alu_ope_o(ope8),
        .alu_sal_i(sal8), .alu_c_i(c8)
    );

    // Behavioural aluN: ADD with optional B inversion/carry-in, AND otherwise.
    always_comb begin
        if (ope4 == 4'b0010) {c4, sal4} = {1'b0, aa4} + {1'b0, (ac4 ? ~ab4 : ab4)} + {4'b0, ac4};
        else                 {c4, sal4} = {1'b0, aa4 & ab4};
    end
    always_comb begin
        if (ope8 == 4'b0010) {c8, sal8} = {1'b0, aa8} + {1'b0, (ac8 ? ~ab8 : ab8)} + {8'b0, ac8};
        else                 {c8, sal8} = {1'b0, aa8 & ab8};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("alu_ope4", 64'(ope4), 64'(4'b0010));
        check("alu_c4",   64'(ac4),  64'd0);
        check("alu_ope8", 64'(ope8), 64'(4'b0010));
        check("alu_c8",   64'(ac8),  64'd0);
    end

    // Issue one N=4 multiply and watch a fixed 12-cycle window; optionally pulse a
    // second start (3x3) at cycle inj of that window.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input int inj,
                        output logic [7:0] p, output int lat, output int ndone, output int nbusy);
        int guard = 0;
        while (busy4 === 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        s4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk);
        #1 s4 = 1'b0;
        p = '0; lat = -1; ndone = 0; nbusy = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy4) nbusy++;
            if (done4) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    p = prod4;
                end
            end
            if (k == inj) begin
                s4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
            end else if (k == inj + 1) begin
                s4 = 1'b0;
            end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
        int guard = 0;
        bit seen = 1'b0;
        while (busy8 === 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        s8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk);
        #1 s8 = 1'b0;
        p = '0; lat = -1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                p = prod8;
                seen = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         inj;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [7:0]  p4;
        logic [15:0] p8;
        logic [7:0]  r8a, r8b;
        int lat, nd, nb, ndone_rst;
        int dq[$];

        vt[0] = '{4'd15, 4'd15, 0, 8'hE1};
        vt[1] = '{4'd13, 4'd11, 0, 8'h8F};
        vt[2] = '{4'd0,  4'd9,  0, 8'h00};
        vt[3] = '{4'd9,  4'd1,  0, 8'h09};
        vt[4] = '{4'd13, 4'd11, 2, 8'h8F};
        vt[5] = '{4'd9,  4'd1,  0, 8'h09};

        rst = 1'b1; s4 = 1'b0; a4 = '0; b4 = '0; s8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_done", 64'(done4), 64'd0);
        check("rst_prod", 64'(prod4), 64'd0);
        check("rst_alu_a", 64'(aa4), 64'd0);
        check("rst_alu_b", 64'(ab4), 64'd0);
        check("rst_prod8", 64'(prod8), 64'd0);

        // Directed table, including start pulsed mid-RUN.
        foreach (vt[i]) begin
            run4(vt[i].a, vt[i].b, vt[i].inj, p4, lat, nd, nb);
            check($sformatf("vec%0d_prod", i), 64'(p4), 64'(vt[i].exp));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d_ndone", i), 64'(nd), 64'd1);
            check($sformatf("vec%0d_busy", i), 64'(nb), 64'd5);
            check($sformatf("vec%0d_hold", i), 64'(prod4), 64'(vt[i].exp));
        end

        // Reset during the second RUN cycle abandons the operation.
        s4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        @(posedge clk);
        #1 s4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy4), 64'd0);
        check("midrst_prod", 64'(prod4), 64'd0);
        check("midrst_done", 64'(done4), 64'd0);
        ndone_rst = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done4) ndone_rst++;
        end
        check("midrst_nodone", 64'(ndone_rst), 64'd0);
        run4(4'd7, 4'd6, 0, p4, lat, nd, nb);
        check("after_rst_prod", 64'(p4), 64'h2A);
        check("after_rst_lat", 64'(lat), 64'd5);

        // Start held high: one accepted start every N+2 cycles.
        s4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (dq.size() > 0 && dq[dq.size()-1] == k - 1)
                check("b2b_stable", 64'(prod4), 64'd15);
            if (done4) begin
                dq.push_back(k);
                check("b2b_prod", 64'(prod4), 64'd15);
            end
        end
        s4 = 1'b0;
        check("b2b_count", 64'(dq.size()), 64'd5);
        foreach (dq[i]) check($sformatf("b2b_at%0d", i), 64'(dq[i]), 64'(5 + 6 * i));
        repeat (8) @(negedge clk);

        // Exhaustive N=4.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y), 0, p4, lat, nd, nb);
                check($sformatf("ex4_%0dx%0d", x, y), 64'(p4), 64'(x * y));
            end

        // N=8 corners then random against a*b.
        run8(8'd255, 8'd255, p8, lat);
        check("n8_max", 64'(p8), 64'hFE01);
        check("n8_lat", 64'(lat), 64'd9);
        run8(8'd0, 8'd255, p8, lat);
        check("n8_zero", 64'(p8), 64'd0);
        run8(8'd128, 8'd2, p8, lat);
        check("n8_128x2", 64'(p8), 64'd256);
        for (int i = 0; i < 1500; i++) begin
            r8a = 8'($urandom);
            r8b = 8'($urandom);
            run8(r8a, r8b, p8, lat);
            check($sformatf("rnd8_%0dx%0d", r8a, r8b), 64'(p8), 64'(int'(r8a) * int'(r8b)));
            check("rnd8_lat", 64'(lat), 64'd9);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
